// File: rtl/decoder_3_8_v.sv
// Registered 3-to-8 decoder: holds each accepted code's one-hot line for HOLD_CYCLES cycles,
// with a one-entry pending buffer. Optional source-protocol check via DECODER_3_8_DROP_DETECT_EN.
module decoder_3_8_v #(
  parameter int unsigned CODE_W      = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [CODE_W-1:0]      i_code,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [2**CODE_W-1:0]   o_onehot,
  output logic                   o_busy,
  output logic                   o_drop
);

  localparam int unsigned OutW     = 2**CODE_W;
  localparam logic [7:0]  HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [OutW-1:0] OneLsb = OutW'(1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q;
  logic [OutW-1:0]   onehot_q;
  logic [7:0]        cnt_q;
  logic              pend_full_q;
  logic [CODE_W-1:0] pend_code_q;
  logic              ready_q;
  logic              xfer;

  function automatic logic [OutW-1:0] decode(input logic [CODE_W-1:0] c);
    decode = OneLsb << c;
  endfunction

  assign xfer = i_valid & ready_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      onehot_q    <= '0;
      cnt_q       <= 8'd0;
      pend_full_q <= 1'b0;
      pend_code_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            onehot_q <= decode(i_code);
            cnt_q    <= HoldLoad;
            state_q  <= StHold;
          end
        end
        StHold: begin
          if (cnt_q == 8'd0) begin
            if (pend_full_q) begin
              onehot_q    <= decode(pend_code_q);
              pend_full_q <= 1'b0;
              cnt_q       <= HoldLoad;
              ready_q     <= 1'b1;
            end else if (xfer) begin
              // Expiry and new transfer coincide: chain straight into the next code.
              onehot_q <= decode(i_code);
              cnt_q    <= HoldLoad;
            end else begin
              onehot_q <= '0;
              state_q  <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
            if (xfer) begin
              pend_code_q <= i_code;
              pend_full_q <= 1'b1;
              ready_q     <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_onehot = onehot_q;
  assign o_busy   = (state_q == StHold) | pend_full_q;

`ifdef DECODER_3_8_DROP_DETECT_EN
  logic [CODE_W-1:0] code_prev_q;
  logic              drop_q;

  // Flags a source that changes i_code while stalled; sticky until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      code_prev_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      code_prev_q <= i_code;
      if (i_valid && !ready_q && (i_code != code_prev_q)) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign o_drop = drop_q;
`else
  assign o_drop = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_3_8_v.sv
// Self-checking bench for decoder_3_8_v: table-driven streaming vectors on a HOLD_CYCLES=4
// instance, plus a HOLD_CYCLES=1 sweep, mid-hold reset and drop-flag sequences.
module tb_decoder_3_8_v;

  logic       clk;
  logic       rst4_n, rst1_n;
  logic [2:0] code4, code1;
  logic       valid4, valid1;
  logic       ready4, ready1;
  logic [7:0] onehot4, onehot1;
  logic       busy4, busy1;
  logic       drop4, drop1;

  int checks;
  int errors;

  decoder_3_8_v #(.CODE_W(3), .HOLD_CYCLES(4)) dut4 (
    .i_clk    (clk),
    .i_rst_n  (rst4_n),
    .i_code   (code4),
    .i_valid  (valid4),
    .o_ready  (ready4),
    .o_onehot (onehot4),
    .o_busy   (busy4),
    .o_drop   (drop4)
  );

  decoder_3_8_v #(.CODE_W(3), .HOLD_CYCLES(1)) dut1 (
    .i_clk    (clk),
    .i_rst_n  (rst1_n),
    .i_code   (code1),
    .i_valid  (valid1),
    .o_ready  (ready1),
    .o_onehot (onehot1),
    .o_busy   (busy1),
    .o_drop   (drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [2:0] code;
    logic [7:0] onehot;
    logic       ready;
    logic       busy;
  } vec_t;

  vec_t tab[$];

`ifdef DECODER_3_8_DROP_DETECT_EN
  localparam logic DropExp = 1'b1;
`else
  localparam logic DropExp = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic v, logic [2:0] c, logic [7:0] oh, logic r, logic b);
    vec_t t;
    t.valid  = v;
    t.code   = c;
    t.onehot = oh;
    t.ready  = r;
    t.busy   = b;
    return t;
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // Idle, single transfer of 3, then back-to-back 5, 0, 7.
    tab.push_back(mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0));
    tab.push_back(mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0));
    tab.push_back(mk(1'b1, 3'd3, 8'h08, 1'b1, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h08, 1'b1, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h08, 1'b1, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h08, 1'b1, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0));
    tab.push_back(mk(1'b1, 3'd5, 8'h20, 1'b1, 1'b1));
    tab.push_back(mk(1'b1, 3'd0, 8'h20, 1'b0, 1'b1));
    tab.push_back(mk(1'b1, 3'd7, 8'h20, 1'b0, 1'b1));
    tab.push_back(mk(1'b1, 3'd7, 8'h20, 1'b0, 1'b1));
    tab.push_back(mk(1'b1, 3'd7, 8'h01, 1'b1, 1'b1));
    tab.push_back(mk(1'b1, 3'd7, 8'h01, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h01, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h01, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h80, 1'b1, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h80, 1'b1, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h80, 1'b1, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h80, 1'b1, 1'b1));
    tab.push_back(mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0));

    rst4_n = 1'b0;
    rst1_n = 1'b0;
    valid4 = 1'b0;
    valid1 = 1'b0;
    code4  = 3'd0;
    code1  = 3'd0;
    tick();
    tick();
    check("rst_onehot", {24'd0, onehot4}, 32'h00);
    check("rst_ready", {31'd0, ready4}, 32'd1);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_drop", {31'd0, drop4}, 32'd0);
    rst4_n = 1'b1;
    rst1_n = 1'b1;

    for (int i = 0; i < tab.size(); i++) begin
      valid4 = tab[i].valid;
      code4  = tab[i].code;
      tick();
      check($sformatf("vec%0d_onehot", i), {24'd0, onehot4}, {24'd0, tab[i].onehot});
      check($sformatf("vec%0d_ready", i), {31'd0, ready4}, {31'd0, tab[i].ready});
      check($sformatf("vec%0d_busy", i), {31'd0, busy4}, {31'd0, tab[i].busy});
    end

    // HOLD_CYCLES=1: consecutive transfers walk the one-hot line with no gaps.
    for (int i = 0; i < 8; i++) begin
      valid1 = 1'b1;
      code1  = 3'(i);
      tick();
      check($sformatf("sweep%0d_onehot", i), {24'd0, onehot1}, 32'(1) << i);
      check($sformatf("sweep%0d_ready", i), {31'd0, ready1}, 32'd1);
    end
    valid1 = 1'b0;
    tick();
    check("sweep_end_onehot", {24'd0, onehot1}, 32'h00);
    check("sweep_end_busy", {31'd0, busy1}, 32'd0);

    // Reset in the second hold cycle of code 6 with code 2 pending.
    valid4 = 1'b1;
    code4  = 3'd6;
    tick();
    check("mid_first_onehot", {24'd0, onehot4}, 32'h40);
    code4 = 3'd2;
    tick();
    check("mid_pending_ready", {31'd0, ready4}, 32'd0);
    valid4 = 1'b0;
    code4  = 3'd0;
    #2;
    rst4_n = 1'b0;
    #1;
    check("mid_rst_onehot", {24'd0, onehot4}, 32'h00);
    check("mid_rst_busy", {31'd0, busy4}, 32'd0);
    check("mid_rst_ready", {31'd0, ready4}, 32'd1);
    tick();
    rst4_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("no_stale%0d", i), {24'd0, onehot4}, 32'h00);
    end

    // Source changes i_code 1 -> 4 while stalled.
    valid4 = 1'b1;
    code4  = 3'd6;
    tick();
    code4 = 3'd1;
    tick();
    check("drop_pre_ready", {31'd0, ready4}, 32'd0);
    check("drop_pre0", {31'd0, drop4}, 32'd0);
    tick();
    check("drop_pre1", {31'd0, drop4}, 32'd0);
    code4 = 3'd4;
    tick();
    check("drop_set", {31'd0, drop4}, {31'd0, DropExp});
    valid4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("drop_sticky%0d", i), {31'd0, drop4}, {31'd0, DropExp});
    end
    check("drop_idle_busy", {31'd0, busy4}, 32'd0);
    rst4_n = 1'b0;
    #1;
    check("drop_rst", {31'd0, drop4}, 32'd0);
    tick();
    rst4_n = 1'b1;
    tick();
    check("drop_after_rst", {31'd0, drop4}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_3_8_v.md
# decoder_3_8_v

Registered 3-to-8 decoder that consumes the `{code, valid}` stream produced by the priority encoders and drives a one-hot output line. Each accepted code is held on its one-hot line for a fixed number of cycles. A valid/ready handshake with a one-entry pending buffer lets back-to-back codes stream without gaps or loss. It sits downstream of `priority_enc_*` blocks in the datapath as the matching decode stage.

## Interface
- `CODE_W`, 3, width of input code; output width is 2**CODE_W.
- `HOLD_CYCLES`, 4, cycles each decoded line stays asserted; legal range 1..255.

- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_code`  in  CODE_W  binary code to decode.
- `i_valid`  in  1  `i_code` is valid this cycle.
- `o_ready`  out  1  block accepts `i_code` this cycle.
- `o_onehot`  out  2**CODE_W  registered one-hot decode; all-zero when idle.
- `o_busy`  out  1  high whenever a line is held or the pending buffer is full.
- `o_drop`  out  1  sticky protocol-error flag; see Configuration.

## Operation
- Transfer occurs on a rising edge when `i_valid & o_ready`.
- State machine:
  - IDLE: `o_onehot` = 0 and `o_ready` = 1. A transfer loads `1 << i_code` into `o_onehot`, sets the counter to HOLD_CYCLES-1, and moves to HOLD.
  - HOLD: `o_onehot` is held.
    - `o_ready` = 1 only when the pending buffer is empty; a transfer in HOLD writes the pending buffer.
    - The counter decrements each cycle.
    - When the counter is 0 and pending is full: load `1 << pending`, clear pending, reload counter to HOLD_CYCLES-1, stay in HOLD.
    - When the counter is 0 and pending is empty: clear `o_onehot` and go to IDLE.
- Simultaneous expiry and transfer with pending empty: the new code loads directly into `o_onehot` (no IDLE cycle) and pending stays empty.
- At most one bit of `o_onehot` is ever set.
- `o_busy` = (state == HOLD) | pending_full.
- Counter width is 8 bits, with no wrap: it only decrements from HOLD_CYCLES-1 down to 0.
- Every value of `i_code` is legal. Source rule: `i_code` must stay stable while `i_valid` is high and `o_ready` is low.

## Timing
- Reset (asynchronous assert; release synchronous to `i_clk`):
  - Outputs: `o_onehot` = 0, `o_ready` = 1, `o_busy` = 0, `o_drop` = 0.
  - Internal: state IDLE, pending empty, counter 0.
- Latency: a code transferred at edge N appears on `o_onehot` immediately after edge N and is held for exactly HOLD_CYCLES cycles.
- `o_ready` is a registered function of state and pending, with no combinational path from `i_valid`.
- Throughput: one code per HOLD_CYCLES cycles sustained. The pending buffer absorbs one extra code.
- HOLD_CYCLES = 1: every code lasts one cycle, and consecutive transfers produce consecutive one-hot cycles.
- Reset asserted mid-HOLD: `o_onehot` clears immediately, the pending code is discarded, and `o_drop` clears.

## Configuration
- Macro `DECODER_3_8_DROP_DETECT_EN`.
- Defined:
  - `o_drop` sets one cycle after any edge where `i_valid` = 1 and `o_ready` = 0 and `i_code` differs from its value on the previous edge (the source broke the hold rule).
  - `o_drop` stays set until reset.
- Not defined: `o_drop` is tied to 0 and the detection logic is not compiled.

## Test plan
- Reset, then idle with `i_valid` = 0 -> `o_onehot` = 8'h00, `o_ready` = 1, `o_busy` = 0.
- Single transfer, `i_code` = 3, HOLD_CYCLES = 4 -> `o_onehot` = 8'h08 for exactly 4 cycles, then 8'h00, `o_busy` falls with it.
- Back-to-back codes 5, 0, 7 with `i_valid` held high:
  - `o_onehot` sequence is 8'h20 ×4, 8'h01 ×4, 8'h80 ×4, with no zero gap.
  - `o_ready` is low while pending is full.
- Sweep `i_code` 0..7 with HOLD_CYCLES = 1 -> `o_onehot` walks 8'h01..8'h80 on consecutive cycles.
- Assert `i_rst_n` low in the 2nd hold cycle of code 6 with code 2 pending -> `o_onehot` = 0 at once. After release, no 8'h04 ever appears.
- With `DECODER_3_8_DROP_DETECT_EN` defined: change `i_code` 1 -> 4 while `o_ready` = 0 -> `o_drop` = 1 next cycle and stays 1 until reset. Without the macro, `o_drop` stays 0.
